// File: rtl/led_pattern_driver.sv
// Command-driven LED bank driver: static, blinking or running patterns on a step tick,
// dimmed by a free-running PWM comparator. Commands arrive on a valid/ready handshake.
module led_pattern_driver #(
   parameter int LED_W    = 4,
   parameter int TICK_DIV = 12_500_000,
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_mode,
   input  logic [LED_W-1:0]    cmd_data,
   input  logic [PWM_BITS-1:0] cmd_duty,
   output logic [LED_W-1:0]    led,
   output logic [1:0]          mode_o,
   output logic                tick_o
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   // Mode states share their encoding with cmd_mode so LOAD can exit by zero-extension.
   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_STATIC = 3'd1,
      S_BLINK  = 3'd2,
      S_RUN    = 3'd3,
      S_LOAD   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          cap_mode_q, cap_mode_d;
   logic [LED_W-1:0]    cap_data_q, cap_data_d;
   logic [PWM_BITS-1:0] cap_duty_q, cap_duty_d;
   logic [1:0]          mode_q, mode_d;
   logic [LED_W-1:0]    pat_q, pat_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic                phase_q, phase_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [LED_W-1:0]    led_q, led_d;

   logic in_load, accept, tick, pwm_on;
   logic [LED_W-1:0] raw;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_OFF;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
      state_d = state_q;
      if (state_q == S_LOAD)
         state_d = state_t'({1'b0, cap_mode_q});
      else if (accept)
         state_d = S_LOAD;
   end

   // FSM outputs
   always_comb begin
      in_load   = (state_q == S_LOAD);
      cmd_ready = !in_load;
   end

   assign accept = cmd_valid & cmd_ready;
   assign tick   = !in_load && (presc_q == TICK_LAST);
   assign pwm_on = (&duty_q) | (pwm_q < duty_q);

   always_comb begin
      case (mode_q)
         2'd1:    raw = pat_q;
         2'd2:    raw = phase_q ? pat_q : '0;
         2'd3:    raw = pat_q;
         default: raw = '0;
      endcase
   end

   always_comb begin
      cap_mode_d = cap_mode_q;
      cap_data_d = cap_data_q;
      cap_duty_d = cap_duty_q;
      mode_d     = mode_q;
      pat_d      = pat_q;
      duty_d     = duty_q;
      phase_d    = phase_q;
      presc_d    = presc_q;
      pwm_d      = pwm_q + 1'b1;
      led_d      = raw & {LED_W{pwm_on}};
      if (in_load) begin
         mode_d  = cap_mode_q;
         pat_d   = cap_data_q;
         duty_d  = cap_duty_q;
         phase_d = 1'b1;
         presc_d = '0;
         pwm_d   = '0;
      end else begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         if (accept) begin
            // A command arriving on a tick cycle overrides that tick's pattern step.
            cap_mode_d = cmd_mode;
            cap_data_d = cmd_data;
            cap_duty_d = cmd_duty;
         end else if (tick) begin
            if (mode_q == 2'd2) phase_d = !phase_q;
            if (mode_q == 2'd3) pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_mode_q <= '0;
         cap_data_q <= '0;
         cap_duty_q <= '0;
         mode_q     <= '0;
         pat_q      <= '0;
         duty_q     <= '0;
         phase_q    <= 1'b0;
         presc_q    <= '0;
         pwm_q      <= '0;
         led_q      <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         cap_mode_q <= cap_mode_d;
         cap_data_q <= cap_data_d;
         cap_duty_q <= cap_duty_d;
         mode_q     <= mode_d;
         pat_q      <= pat_d;
         duty_q     <= duty_d;
         phase_q    <= phase_d;
         presc_q    <= presc_d;
         pwm_q      <= pwm_d;
         led_q      <= led_d;
      end
   end

   assign led    = led_q;
   assign mode_o = mode_q;
   assign tick_o = tick;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Randomised and directed bench for led_pattern_driver, checked cycle by cycle against a
// behavioural model of the command, step and PWM rules.
module tb_led_pattern_driver;

   localparam int TD = 4;

   logic       clk, rst_n, cmd_valid, cmd_ready, tick_o;
   logic [1:0] cmd_mode, mode_o;
   logic [3:0] cmd_data, led;
   logic [7:0] cmd_duty;

   led_pattern_driver #(.LED_W(4), .TICK_DIV(TD), .PWM_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_data(cmd_data), .cmd_duty(cmd_duty),
      .led(led), .mode_o(mode_o), .tick_o(tick_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_lit    = 0;
   int n_acc    = 0;

   // Behavioural model
   bit       m_load;
   int       m_cap_mode, m_cap_data, m_cap_duty;
   int       m_mode, m_pat, m_duty, m_phase, m_presc, m_pwm, m_led;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_load = 0; m_cap_mode = 0; m_cap_data = 0; m_cap_duty = 0;
      m_mode = 0; m_pat = 0; m_duty = 0; m_phase = 0; m_presc = 0; m_pwm = 0; m_led = 0;
   endtask

   function automatic int raw_of(int mode, int pat, int phase);
      case (mode)
         1: return pat;
         2: return phase ? pat : 0;
         3: return pat;
         default: return 0;
      endcase
   endfunction

   task automatic compare_all();
      check("cmd_ready", 32'(cmd_ready), 32'(!m_load));
      check("mode_o", 32'(mode_o), 32'(m_mode));
      check("tick_o", 32'(tick_o), 32'(!m_load && m_presc == TD - 1));
      check("led", 32'(led), 32'(m_led));
   endtask

   // One clock cycle: drive inputs, advance the model across the edge, compare afterwards.
   task automatic cycle(input bit v, input int md, input int d, input int du);
      bit acc, tk;
      int next_led;
      cmd_valid = v;
      cmd_mode  = 2'(md);
      cmd_data  = 4'(d);
      cmd_duty  = 8'(du);
      acc = v && !m_load;
      if (cmd_valid && cmd_ready) n_acc++;
      @(posedge clk);
      next_led = ((m_duty == 255) || (m_pwm < m_duty)) ? raw_of(m_mode, m_pat, m_phase) : 0;
      if (m_load) begin
         m_mode = m_cap_mode; m_pat = m_cap_data; m_duty = m_cap_duty;
         m_phase = 1; m_presc = 0; m_pwm = 0; m_load = 0;
      end else begin
         tk = (m_presc == TD - 1);
         m_presc = (m_presc + 1) % TD;
         m_pwm = (m_pwm + 1) % 256;
         if (acc) begin
            m_cap_mode = md; m_cap_data = d; m_cap_duty = du; m_load = 1;
         end else if (tk) begin
            if (m_mode == 2) m_phase = 1 - m_phase;
            if (m_mode == 3) m_pat = ((m_pat * 2) | (m_pat / 8)) % 16;
         end
      end
      m_led = next_led;
      @(negedge clk);
      if (led != 4'd0) n_lit++;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_data = '0; cmd_duty = '0;
      model_reset();
      #12;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Static pattern at full brightness
      cycle(1, 1, 4'b1010, 255);
      idle(8);

      // Blink and tick cadence
      cycle(1, 2, 4'b1111, 255);
      idle(20);

      // Running light
      cycle(1, 3, 4'b0001, 255);
      idle(24);

      // PWM duty 64 and duty 0
      cycle(1, 1, 4'b1111, 64);
      idle(2);
      n_lit = 0;
      idle(256);
      check("duty64_lit_cycles", 32'(n_lit), 32'd64);
      cycle(1, 1, 4'b1111, 0);
      idle(2);
      n_lit = 0;
      idle(256);
      check("duty0_lit_cycles", 32'(n_lit), 32'd0);

      // cmd_valid held three cycles: only two acceptances
      n_acc = 0;
      cycle(1, 1, 4'b0011, 255);
      cycle(1, 3, 4'b1000, 255);
      cycle(1, 3, 4'b1000, 255);
      check("held_valid_accepts", 32'(n_acc), 32'd2);
      idle(12);

      // Command accepted exactly on a tick cycle while running
      for (int i = 0; i < 2 * TD && !(!m_load && m_presc == TD - 1); i++) idle(1);
      check("tick_cycle_found", 32'(!m_load && m_presc == TD - 1), 32'd1);
      cycle(1, 2, 4'b0110, 255);
      idle(10);

      // Asynchronous reset in the middle of blinking
      cycle(1, 2, 4'b1111, 255);
      idle(3);
      check("blink_lit_before_reset", 32'(led), 32'hF);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("async_rst_led", 32'(led), 32'd0);
      check("async_rst_ready", 32'(cmd_ready), 32'd1);
      check("async_rst_mode", 32'(mode_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      compare_all();

      // Randomised commands
      for (int i = 0; i < 800; i++) begin
         int du, sel;
         sel = int'($urandom_range(0, 3));
         du  = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom_range(0, 255));
         cycle($urandom_range(0, 9) == 0, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 15)), du);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
